// File: rtl/dma_request_handler.sv
// dma_request_handler: front end of a 4-channel DMA controller.
//
// What it does:
//   - Conditions raw DREQ lines into reqPending for the priority stage.
//   - Holds the mask and software-request registers.
//   - Runs the HRQ/HLDA bus-hold handshake with the CPU.
//   - Gates the priority stage's DACK drive through assertDACK.
//
// Build option: define DREQ_SYNC_EN to get a 2-flop synchroniser on each
// DREQ bit (reqPending lags DREQ by 3 edges). The default build samples
// DREQ with one flop (2-edge lag).
module dma_request_handler #(
  parameter int NUM_CH       = 4,
  parameter int HOLD_TIMEOUT = 15
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_CH-1:0]             DREQ,
  input  logic                          dreqSenseLow,
  input  logic                          dmaDisable,
  input  logic                          maskSingleWr,
  input  logic [$clog2(NUM_CH):0]       maskSingleData,
  input  logic                          maskAllWr,
  input  logic [NUM_CH-1:0]             maskAllData,
  input  logic                          swReqWr,
  input  logic [$clog2(NUM_CH):0]       swReqData,
  input  logic                          TC,
  input  logic [$clog2(NUM_CH)-1:0]     tcChannel,
  input  logic [NUM_CH-1:0]             autoInit,
  input  logic                          HLDA,
  input  logic                          serviceDone,
  output logic                          HRQ,
  output logic                          assertDACK,
  output logic [NUM_CH-1:0]             reqPending,
  output logic [NUM_CH-1:0]             maskReg,
  output logic [NUM_CH-1:0]             reqReg
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hrq_q;
  logic              dack_q;
  logic [NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] hw_req;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] mask_d;
  logic [NUM_CH-1:0] sreq_q;
  logic [NUM_CH-1:0] sreq_d;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;

`ifdef DREQ_SYNC_EN
  logic [NUM_CH-1:0] meta_q;

  // Two-flop synchroniser: DREQ comes from asynchronous peripherals.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= DREQ;
      sync_q <= meta_q;
    end
  end
`else
  // Single sampling flop: the requesters are assumed to be synchronous to CLK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= DREQ;
  end
`endif

  // Normalise polarity so the rest of the block always treats 1 as "request".
  assign hw_req = sync_q ^ {NUM_CH{dreqSenseLow}};

  // Mask / software-request next state.
  // TC is applied first, then the register writes. This makes a
  // same-cycle write to the same bit take priority over TC.
  // maskAllWr covers every bit, so it also beats a single-bit mask write.
  always_comb begin
    mask_d = mask_q;
    sreq_d = sreq_q;
    if (TC) begin
      sreq_d[tcChannel] = 1'b0;
      if (!autoInit[tcChannel]) mask_d[tcChannel] = 1'b1;
    end
    if (swReqWr) sreq_d[swReqData[CH_W-1:0]] = swReqData[CH_W];
    if (maskAllWr)         mask_d = maskAllData;
    else if (maskSingleWr) mask_d[maskSingleData[CH_W-1:0]] = maskSingleData[CH_W];
  end

  // Software requests bypass the mask so the CPU can always kick a channel.
  assign pend_d = (hw_req & ~mask_q) | sreq_q;

  // Register file and the registered request vector seen by the priority stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= {NUM_CH{1'b1}};
      sreq_q <= '0;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      sreq_q <= sreq_d;
      pend_q <= pend_d;
    end
  end

  // Saturating increment of the hold-wait counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Hold-request FSM; HRQ and assertDACK are registered alongside the state.
  // IDLE always lasts at least one cycle, so HRQ is low for a cycle between
  // bus tenures. A timeout in REQ releases HRQ so the CPU is not starved
  // by an acknowledge that never comes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hrq_q   <= 1'b0;
      dack_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((|pend_q) && !dmaDisable) begin
            state_q <= S_REQ;
            cnt_q   <= '0;
            hrq_q   <= 1'b1;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_inc;
          if (HLDA) begin
            state_q <= S_GRANT;
            dack_q  <= 1'b1;
          end else if (!(|pend_q) || (cnt_inc >= TMO)) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
          end
        end
        S_GRANT: begin
          // dmaDisable is deliberately ignored here: a started transfer completes.
          if (serviceDone || !HLDA) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          hrq_q   <= 1'b0;
          dack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HRQ        = hrq_q;
  assign assertDACK = dack_q;
  assign reqPending = pend_q;
  assign maskReg    = mask_q;
  assign reqReg     = sreq_q;

endmodule

// File: tb/tb_dma_request_handler.sv
// Directed bench for dma_request_handler. Expected values are queued
// as stimulus is applied and popped when the DUT output is sampled.
module tb_dma_request_handler;

`ifdef DREQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       dreqSenseLow, dmaDisable;
  logic       maskSingleWr;
  logic [2:0] maskSingleData;
  logic       maskAllWr;
  logic [3:0] maskAllData;
  logic       swReqWr;
  logic [2:0] swReqData;
  logic       TC;
  logic [1:0] tcChannel;
  logic [3:0] autoInit;
  logic       HLDA, serviceDone;
  logic       HRQ, assertDACK;
  logic [3:0] reqPending, maskReg, reqReg;

  int checks = 0;
  int errors = 0;
  string      exp_tag[$];
  logic [7:0] exp_val[$];

  dma_request_handler #(.NUM_CH(4), .HOLD_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreqSenseLow(dreqSenseLow),
    .dmaDisable(dmaDisable), .maskSingleWr(maskSingleWr),
    .maskSingleData(maskSingleData), .maskAllWr(maskAllWr),
    .maskAllData(maskAllData), .swReqWr(swReqWr), .swReqData(swReqData),
    .TC(TC), .tcChannel(tcChannel), .autoInit(autoInit), .HLDA(HLDA),
    .serviceDone(serviceDone), .HRQ(HRQ), .assertDACK(assertDACK),
    .reqPending(reqPending), .maskReg(maskReg), .reqReg(reqReg)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string t, input logic [7:0] v);
    exp_tag.push_back(t);
    exp_val.push_back(v);
  endtask

  task automatic chk(input logic [7:0] obs);
    string      t;
    logic [7:0] ev;
    checks++;
    if (exp_tag.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty obs=%0h exp=<none>", obs);
    end else begin
      t  = exp_tag.pop_front();
      ev = exp_val.pop_front();
      assert (obs === ev) else begin
        errors++;
        $display("FAIL %s obs=%0h exp=%0h", t, obs, ev);
        $error("check %s", t);
      end
    end
  endtask

  initial begin
    int hcnt;
    RESET = 1'b1; DREQ = '0; dreqSenseLow = 1'b0; dmaDisable = 1'b0;
    maskSingleWr = 1'b0; maskSingleData = '0; maskAllWr = 1'b0; maskAllData = '0;
    swReqWr = 1'b0; swReqData = '0; TC = 1'b0; tcChannel = '0; autoInit = '0;
    HLDA = 1'b0; serviceDone = 1'b0;

    // Reset state
    #12;
    push("rst_mask", 8'h0F); chk(maskReg);
    push("rst_req",  8'h00); chk(reqReg);
    push("rst_pend", 8'h00); chk(reqPending);
    push("rst_hrq",  8'h00); chk(HRQ);
    push("rst_dack", 8'h00); chk(assertDACK);
    tick();
    RESET = 1'b0;

    // Unmask all, raise DREQ[2]: reqPending after LAT edges, HRQ one edge later
    maskAllWr = 1'b1; maskAllData = 4'b0000;
    push("mask_all_clr", 8'h00);
    tick(); maskAllWr = 1'b0;
    chk(maskReg);
    DREQ = 4'b0100;
    push("pend_early", 8'h00);
    repeat (LAT-1) tick();
    chk(reqPending);
    push("pend_lat", 8'h04);
    push("hrq_not_yet", 8'h00);
    tick();
    chk(reqPending);
    chk(HRQ);
    push("hrq_rise", 8'h01);
    tick(); chk(HRQ);

    // HLDA -> GRANT; dmaDisable must not abort; serviceDone ends tenure
    HLDA = 1'b1;
    push("dack_grant", 8'h01);
    push("hrq_grant", 8'h01);
    tick(); chk(assertDACK); chk(HRQ);
    dmaDisable = 1'b1;
    push("dack_dis_hold", 8'h01);
    tick(); chk(assertDACK);
    dmaDisable = 1'b0;
    serviceDone = 1'b1; HLDA = 1'b0;
    push("hrq_done", 8'h00);
    push("dack_done", 8'h00);
    tick(); serviceDone = 1'b0;
    chk(HRQ); chk(assertDACK);
    push("hrq_rereq", 8'h01);
    tick(); chk(HRQ);

    // HLDA never comes: HRQ held for exactly 15 cycles, back after one idle cycle
    hcnt = 0;
    while (HRQ && hcnt < 40) begin
      hcnt++;
      tick();
    end
    push("timeout_cycles", 8'd15);
    chk(8'(hcnt));
    push("hrq_after_idle", 8'h01);
    tick(); chk(HRQ);

    // dmaDisable blocks new HRQ while the request stays pending
    dmaDisable = 1'b1;
    hcnt = 0;
    while (HRQ && hcnt < 40) begin
      hcnt++;
      tick();
    end
    repeat (3) tick();
    push("hrq_disabled", 8'h00);
    push("pend_disabled", 8'h04);
    chk(HRQ); chk(reqPending);
    dmaDisable = 1'b0;
    push("hrq_enabled", 8'h01);
    tick(); chk(HRQ);
    DREQ = 4'b0000;
    push("hrq_drop_nopend", 8'h00);
    repeat (LAT+2) tick();
    chk(HRQ);

    // Active-low DREQ
    dreqSenseLow = 1'b1; DREQ = 4'b1110;
    push("pend_senselow", 8'h01);
    repeat (LAT) tick();
    chk(reqPending);
    maskSingleWr = 1'b1; maskSingleData = 3'b100;
    push("mask_single_set0", 8'h01);
    tick(); maskSingleWr = 1'b0;
    chk(maskReg);
    push("pend_masked", 8'h00);
    tick(); chk(reqPending);
    maskAllWr = 1'b1; maskAllData = 4'b1010;
    maskSingleWr = 1'b1; maskSingleData = 3'b100;
    push("mask_all_wins", 8'h0A);
    tick(); maskAllWr = 1'b0; maskSingleWr = 1'b0;
    chk(maskReg);
    dreqSenseLow = 1'b0; DREQ = 4'b0000;
    repeat (LAT+2) tick();

    // TC with autoInit=0: clear sw request, set mask
    maskAllWr = 1'b1; maskAllData = 4'b0000; tick(); maskAllWr = 1'b0;
    autoInit = 4'b0000;
    swReqWr = 1'b1; swReqData = 3'b110;
    push("swreq_set2", 8'h04);
    tick(); swReqWr = 1'b0;
    chk(reqReg);
    push("pend_swreq", 8'h04);
    tick(); chk(reqPending);
    TC = 1'b1; tcChannel = 2'd2;
    push("tc_mask", 8'h04);
    push("tc_req", 8'h00);
    tick(); TC = 1'b0;
    chk(maskReg); chk(reqReg);

    // TC with autoInit[2]=1: mask untouched
    autoInit = 4'b0100;
    maskAllWr = 1'b1; maskAllData = 4'b0000; tick(); maskAllWr = 1'b0;
    swReqWr = 1'b1; swReqData = 3'b110; tick(); swReqWr = 1'b0;
    TC = 1'b1; tcChannel = 2'd2;
    push("tc_ai_mask", 8'h00);
    push("tc_ai_req", 8'h00);
    tick(); TC = 1'b0;
    chk(maskReg); chk(reqReg);

    // Same-cycle register writes beat TC
    autoInit = 4'b0000;
    TC = 1'b1; tcChannel = 2'd2;
    swReqWr = 1'b1; swReqData = 3'b110;
    maskSingleWr = 1'b1; maskSingleData = 3'b010;
    push("wr_beats_tc_req", 8'h04);
    push("wr_beats_tc_mask", 8'h00);
    tick(); TC = 1'b0; swReqWr = 1'b0; maskSingleWr = 1'b0;
    chk(reqReg); chk(maskReg);

    // Software request ignores mask
    maskAllWr = 1'b1; maskAllData = 4'b1111; tick(); maskAllWr = 1'b0;
    push("swreq_bypass_mask", 8'h04);
    tick(); chk(reqPending);

    // Reach GRANT, then reset asynchronously mid-cycle
    HLDA = 1'b1;
    hcnt = 0;
    while (!assertDACK && hcnt < 40) begin
      hcnt++;
      tick();
    end
    push("dack_before_rst", 8'h01);
    chk(assertDACK);
    #2 RESET = 1'b1;
    #1;
    push("arst_hrq", 8'h00);
    push("arst_dack", 8'h00);
    push("arst_mask", 8'h0F);
    push("arst_req", 8'h00);
    chk(HRQ); chk(assertDACK); chk(maskReg); chk(reqReg);
    HLDA = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    push("post_rst_hrq", 8'h00);
    tick(); chk(HRQ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
